// File: rtl/ann_mac_scheduler.sv
// ann_mac_scheduler
//   Sequences the ANN multiply-accumulate datapath for one classification
//   pass: walks NUM_NEURONS neurons x NUM_INPUTS coefficients, fetches each
//   coefficient over a req/ready handshake and strobes the accumulator.
//
// Ports
//   clk_i            system clock, rising edge
//   n_rst_i          asynchronous active-low reset
//   start_i          begin a pass (only looked at in IDLE)
//   image_loaded_i   level, input image buffer valid
//   abort_i          synchronous cancel of the current pass
//   coeff_ready_i    coefficient at coeff_addr_o is valid this cycle
//   coeff_req_o      coefficient read request
//   coeff_addr_o     neuron_idx*NUM_INPUTS + input_idx
//   input_idx_o      current input index (image buffer select)
//   neuron_idx_o     current neuron index
//   acc_clear_o      clear accumulator
//   mac_en_o         accumulate coefficient x input this cycle
//   store_en_o       write accumulator to result slot neuron_idx_o
//   busy_o           high in every state except IDLE
//   done_o           one-cycle pulse at end of pass
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start, all outputs low
// WAIT_IMG | start seen, waiting for the image buffer
// CLEAR    | clear accumulator for the current neuron
// REQ      | request coefficient, hold until coeff_ready_i
// MAC      | accumulate one product
// STORE    | write accumulator for the current neuron
// DONE     | pass complete pulse

module ann_mac_scheduler #(
   parameter int NUM_INPUTS  = 64,
   parameter int NUM_NEURONS = 10,
   parameter int IN_W        = 6,
   parameter int NEU_W       = 4,
   parameter int ADDR_W      = 10
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              start_i,
   input  logic              image_loaded_i,
   input  logic              abort_i,
   input  logic              coeff_ready_i,
   output logic              coeff_req_o,
   output logic [ADDR_W-1:0] coeff_addr_o,
   output logic [IN_W-1:0]   input_idx_o,
   output logic [NEU_W-1:0]  neuron_idx_o,
   output logic              acc_clear_o,
   output logic              mac_en_o,
   output logic              store_en_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_IMG = 3'd1,
      CLEAR    = 3'd2,
      REQ      = 3'd3,
      MAC      = 3'd4,
      STORE    = 3'd5,
      DONE     = 3'd6
   } state_e;

   localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(NUM_INPUTS - 1);
   localparam logic [NEU_W-1:0] NEU_LAST = NEU_W'(NUM_NEURONS - 1);

   state_e              state_q, state_d;
   logic [IN_W-1:0]     in_idx_q, in_idx_d;
   logic [NEU_W-1:0]    neu_idx_q, neu_idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_q   <= IDLE;
         in_idx_q  <= '0;
         neu_idx_q <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         neu_idx_q <= neu_idx_d;
         addr_q    <= addr_d;
      end
   end

   // The address is a running counter that advances together with the
   // indices (next input, or next neuron at input 0), so it always equals
   // neuron_idx*NUM_INPUTS + input_idx without a multiplier.
   always_comb begin
      state_d   = state_q;
      in_idx_d  = in_idx_q;
      neu_idx_d = neu_idx_q;
      addr_d    = addr_q;

      // abort wins over everything; in IDLE it also suppresses start
      if (abort_i) begin
         state_d   = IDLE;
         in_idx_d  = '0;
         neu_idx_d = '0;
         addr_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d = image_loaded_i ? CLEAR : WAIT_IMG;
               end
            end
            WAIT_IMG: begin
               if (image_loaded_i) begin
                  state_d = CLEAR;
               end
            end
            CLEAR: begin
               in_idx_d = '0;
               state_d  = REQ;
            end
            REQ: begin
               if (coeff_ready_i) begin
                  state_d = MAC;
               end
            end
            MAC: begin
               if (in_idx_q == IN_LAST) begin
                  state_d = STORE;
               end else begin
                  in_idx_d = in_idx_q + IN_W'(1);
                  addr_d   = addr_q + ADDR_W'(1);
                  state_d  = REQ;
               end
            end
            STORE: begin
               if (neu_idx_q == NEU_LAST) begin
                  state_d = DONE;
               end else begin
                  neu_idx_d = neu_idx_q + NEU_W'(1);
                  in_idx_d  = '0;
                  addr_d    = addr_q + ADDR_W'(1);
                  state_d   = CLEAR;
               end
            end
            DONE: begin
               state_d   = IDLE;
               in_idx_d  = '0;
               neu_idx_d = '0;
               addr_d    = '0;
            end
            default: begin
               state_d   = IDLE;
               in_idx_d  = '0;
               neu_idx_d = '0;
               addr_d    = '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      coeff_req_o  = (state_q == REQ);
      acc_clear_o  = (state_q == CLEAR);
      mac_en_o     = (state_q == MAC);
      store_en_o   = (state_q == STORE);
      done_o       = (state_q == DONE);
      busy_o       = (state_q != IDLE);
      coeff_addr_o = addr_q;
      input_idx_o  = in_idx_q;
      neuron_idx_o = neu_idx_q;
   end

endmodule

// File: tb/tb_ann_mac_scheduler.sv
module tb_ann_mac_scheduler;

   localparam int NI = 4;
   localparam int NN = 2;

   localparam int K_CLEAR = 0;
   localparam int K_MAC   = 1;
   localparam int K_STORE = 2;
   localparam int K_DONE  = 3;

   typedef struct {
      int kind;
      int neu;
      int inp;
      int addr;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       n_rst, start, image_loaded, abort, coeff_ready;
   logic       coeff_req, acc_clear, mac_en, store_en, busy, done;
   logic [2:0] coeff_addr;
   logic [1:0] input_idx;
   logic [0:0] neuron_idx;

   logic       start64;
   logic       req64, clr64, mac64, st64, busy64, done64;
   logic [9:0] addr64;
   logic [5:0] in64;
   logic [3:0] neu64;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   ev_t exp_q[$];
   int stall[8];
   bit noise = 1'b0;

   int st64_cnt, done64_cnt, done64_cyc, max64;

   ann_mac_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .IN_W(2), .NEU_W(1), .ADDR_W(3)) dut (
      .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .image_loaded_i(image_loaded),
      .abort_i(abort), .coeff_ready_i(coeff_ready), .coeff_req_o(coeff_req),
      .coeff_addr_o(coeff_addr), .input_idx_o(input_idx), .neuron_idx_o(neuron_idx),
      .acc_clear_o(acc_clear), .mac_en_o(mac_en), .store_en_o(store_en),
      .busy_o(busy), .done_o(done)
   );

   ann_mac_scheduler dut64 (
      .clk_i(clk), .n_rst_i(n_rst), .start_i(start64), .image_loaded_i(image_loaded),
      .abort_i(abort), .coeff_ready_i(1'b1), .coeff_req_o(req64),
      .coeff_addr_o(addr64), .input_idx_o(in64), .neuron_idx_o(neu64),
      .acc_clear_o(clr64), .mac_en_o(mac64), .store_en_o(st64),
      .busy_o(busy64), .done_o(done64)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic check_zero(input string name);
      chk(name, {20'd0, coeff_req, coeff_addr, input_idx, neuron_idx,
                 acc_clear, mac_en, store_en, busy, done}, 32'd0);
   endtask

   // Reference: a pass is, per neuron, one clear, NUM_INPUTS fetch+MAC pairs
   // (each fetch lasting 1 + stall cycles) and one store; then one done.
   task automatic push_pass(input int base);
      int t;
      t = base;
      for (int n = 0; n < NN; n++) begin
         exp_q.push_back('{K_CLEAR, n, 0, n*NI, t});
         t++;
         for (int i = 0; i < NI; i++) begin
            t += stall[n*NI+i] + 1;
            exp_q.push_back('{K_MAC, n, i, n*NI+i, t});
            t++;
         end
         exp_q.push_back('{K_STORE, n, NI-1, n*NI+NI-1, t});
         t++;
      end
      exp_q.push_back('{K_DONE, 0, 0, 0, t});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_pass();
      image_loaded = 1'b1;
      start = 1'b1;
      push_pass(cyc + 1);
      next_cycle();
      start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         next_cycle();
         n++;
         if (noise && exp_q.size() != 0) begin
            start = 1'($urandom);
            image_loaded = 1'($urandom);
         end
      end
      start = 1'b0;
      image_loaded = 1'b1;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Coefficient memory: withholds ready for stall[addr] REQ cycles, and
   // optionally toggles ready randomly outside REQ.
   initial begin
      int scnt;
      scnt = 0;
      coeff_ready = 1'b0;
      forever begin
         next_cycle();
         if (coeff_req) begin
            if (scnt < stall[coeff_addr]) begin
               coeff_ready = 1'b0;
               scnt++;
            end else begin
               coeff_ready = 1'b1;
               scnt = 0;
            end
         end else begin
            scnt = 0;
            coeff_ready = noise ? 1'($urandom) : 1'b0;
         end
      end
   end

   // Scoreboard monitor for the small instance.
   initial begin
      int ns, kind;
      ev_t e;
      forever begin
         @(negedge clk);
         ns = int'(acc_clear) + int'(mac_en) + int'(store_en) + int'(done);
         if (ns > 1) chk("one_strobe", ns, 1);
         if (ns == 1) begin
            kind = acc_clear ? K_CLEAR : mac_en ? K_MAC : store_en ? K_STORE : K_DONE;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none", kind, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("kind", kind, e.kind);
               chk("cycle", cyc, e.cyc);
               if (e.kind != K_DONE) begin
                  chk("addr", coeff_addr, e.addr);
                  chk("neuron", neuron_idx, e.neu);
                  chk("input", input_idx, e.inp);
                  chk("busy", busy, 1);
               end
            end
         end else if (coeff_req) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_MAC) begin
               tests++;
               fails++;
               $display("FAIL unexpected_req: got coeff_req at cycle %0d, required none", cyc);
            end else begin
               chk("req_addr", coeff_addr, exp_q[0].addr);
               chk("req_neuron", neuron_idx, exp_q[0].neu);
               chk("req_input", input_idx, exp_q[0].inp);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (st64) st64_cnt++;
         if (int'(addr64) > max64) max64 = int'(addr64);
         if (done64) begin
            done64_cnt++;
            done64_cyc = cyc;
         end
      end
   end

   initial begin
      int c0;
      n_rst = 1'b0;
      start = 1'b0;
      start64 = 1'b0;
      abort = 1'b0;
      image_loaded = 1'b0;
      for (int i = 0; i < 8; i++) stall[i] = 0;
      repeat (3) next_cycle();
      check_zero("reset_outputs");
      n_rst = 1'b1;
      next_cycle();
      check_zero("idle_outputs");

      // 1: plain pass, ready always granted
      begin_pass();
      drain(100);
      next_cycle();
      check_zero("t1_after_done");

      // 2: three stall cycles on address 5
      stall[5] = 3;
      begin_pass();
      drain(100);
      stall[5] = 0;
      next_cycle();

      // 3: start before the image is ready
      image_loaded = 1'b0;
      c0 = cyc;
      start = 1'b1;
      push_pass(c0 + 7);
      next_cycle();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         chk("t3_busy", busy, 1);
         chk("t3_no_clear", acc_clear, 0);
         if (k == 6) image_loaded = 1'b1;
         else next_cycle();
      end
      drain(100);
      next_cycle();

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      next_cycle();
      start = 1'b0;
      abort = 1'b0;
      check_zero("start_abort_idle");
      next_cycle();
      check_zero("start_abort_idle2");

      // 4: abort at cycle 8
      c0 = cyc;
      begin_pass();
      while (cyc < c0 + 8) next_cycle();
      abort = 1'b1;
      next_cycle();
      abort = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         check_zero("t4_after_abort");
         next_cycle();
      end
      begin_pass();
      drain(100);
      next_cycle();

      // 5: start pulses mid-pass are ignored; async reset at cycle 12
      c0 = cyc;
      begin_pass();
      while (cyc < c0 + 12) begin
         next_cycle();
         start = (cyc == c0 + 3) || (cyc == c0 + 5) || (cyc == c0 + 8);
      end
      start = 1'b0;
      #2;
      n_rst = 1'b0;
      exp_q.delete();
      #1;
      check_zero("t5_async_reset");
      next_cycle();
      check_zero("t5_in_reset");
      n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         check_zero("t5_after_reset");
      end

      // randomized passes: random stalls, noise on start/image/ready
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 8; i++)
            stall[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         begin_pass();
         noise = 1'b1;
         drain(200);
         noise = 1'b0;
         next_cycle();
         check_zero("rand_idle_after");
         repeat ($urandom_range(0, 3)) next_cycle();
      end
      for (int i = 0; i < 8; i++) stall[i] = 0;

      // 6: default geometry 64x10
      st64_cnt = 0;
      done64_cnt = 0;
      done64_cyc = -1;
      max64 = 0;
      c0 = cyc;
      start64 = 1'b1;
      next_cycle();
      start64 = 1'b0;
      while (done64_cnt == 0 && cyc < c0 + 1400) next_cycle();
      repeat (5) next_cycle();
      chk("t6_done_cycle", done64_cyc - c0, 1301);
      chk("t6_done_count", done64_cnt, 1);
      chk("t6_store_count", st64_cnt, 10);
      chk("t6_max_addr", max64, 639);
      chk("t6_idle_busy", busy64, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
